// File: rtl/soc_pkg.sv
// Shared SoC bus types plus the RAM loader state encoding.
package soc_pkg;
  localparam int SOC_DATA_W = 32;
  localparam int SOC_ADDR_W = 32;
  localparam int SOC_BYTES  = SOC_DATA_W / 8;
  localparam int SOC_ADDRL  = $clog2(SOC_BYTES);
  localparam int HI         = SOC_DATA_W - 1;

  typedef logic [HI:0]           soc_data_t;
  typedef logic [SOC_BYTES-1:0]  soc_we_t;
  typedef logic [SOC_ADDR_W-1:0] soc_addr_t;

  // Loader FSM encoding, visible to the boot controller for status decode.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ldr_state_t;
endpackage

// File: rtl/soc_if.sv
// SoC RAM bus: master drives a request, slave answers with rdy.
interface soc_if;
  import soc_pkg::*;

  logic      vld;
  soc_we_t   we;
  soc_addr_t addr;
  soc_data_t wdat;
  logic      rdy;

  modport MST (output vld, output we, output addr, output wdat, input rdy);
  modport SLV (input vld, input we, input addr, input wdat, output rdy);
endinterface

// File: rtl/soc_ram_loader.sv
// Byte-stream to SoC RAM loader: packs bytes little-endian into words and
// writes them sequentially from BASE_ADDR, tracking count, checksum, overflow.
module soc_ram_loader
  import soc_pkg::*;
#(
  parameter soc_addr_t BASE_ADDR = '0,
  parameter int        NUM_WORDS = 1024,
  localparam int       WCNT_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              arst_n,
  soc_if.MST                bus,
  input  logic              start,
  input  logic              s_vld,
  output logic              s_rdy,
  input  logic [7:0]        s_dat,
  input  logic              s_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WCNT_W-1:0] wcnt,
  output logic [15:0]       csum
);

  ldr_state_t           state_q, state_d;
  logic [SOC_ADDRL-1:0] lane_idx_q, lane_idx_d;
  soc_data_t            word_q, word_d;
  soc_we_t              we_acc_q, we_acc_d;
  soc_addr_t            addr_q, addr_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [15:0]          csum_q, csum_d;
  logic                 err_q, err_d;
  logic                 last_q, last_d;

  logic byte_xfer;
  assign byte_xfer = s_vld & s_rdy;

  // State and datapath registers; reset drops any in-flight bus request at once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      word_q     <= '0;
      we_acc_q   <= '0;
      addr_q     <= BASE_ADDR;
      wcnt_q     <= '0;
      csum_q     <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      word_q     <= word_d;
      we_acc_q   <= we_acc_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      csum_q     <= csum_d;
      err_q      <= err_d;
      last_q     <= last_d;
    end
  end

  // Next-state logic including the inline byte packer.
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    word_d     = word_q;
    we_acc_d   = we_acc_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    csum_d     = csum_q;
    err_d      = err_q;
    last_d     = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILL;
          lane_idx_d = '0;
          word_d     = '0;
          we_acc_d   = '0;
          addr_d     = BASE_ADDR;
          wcnt_d     = '0;
          csum_d     = '0;
          err_d      = 1'b0;
          last_d     = 1'b0;
        end
      end
      FILL: begin
        if (byte_xfer) begin
          if (wcnt_q == WCNT_W'(NUM_WORDS)) begin
            // Region full: the byte is swallowed without touching csum.
            err_d   = 1'b1;
            state_d = s_last ? DONE : DRAIN;
          end else begin
            word_d[{lane_idx_q, 3'b000} +: 8] = s_dat;
            we_acc_d[lane_idx_q]              = 1'b1;
            csum_d                            = csum_q + 16'(s_dat);
            lane_idx_d                        = lane_idx_q + 1'b1;
            last_d                            = s_last;
            if (s_last || lane_idx_q == SOC_ADDRL'(SOC_BYTES - 1)) begin
              state_d = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (bus.rdy) begin
          wcnt_d     = wcnt_q + WCNT_W'(1);
          addr_d     = addr_q + soc_addr_t'(SOC_BYTES);
          we_acc_d   = '0;
          lane_idx_d = '0;
          word_d     = '0;
          state_d    = last_q ? DONE : FILL;
        end
      end
      DRAIN: begin
        if (byte_xfer && s_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus request is held stable through WRITE; we/wdat forced to zero otherwise.
  always_comb begin
    bus.vld  = (state_q == WRITE);
    bus.we   = bus.vld ? we_acc_q : '0;
    bus.wdat = bus.vld ? word_q : '0;
    bus.addr = addr_q;
  end

  assign s_rdy = (state_q == FILL) || (state_q == DRAIN);
  assign busy  = (state_q == FILL) || (state_q == WRITE) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign err   = err_q;
  assign wcnt  = wcnt_q;
  assign csum  = csum_q;

`ifdef SIM_ONLY
`ifdef LDR_DEBUG
  // Trace every committed write.
  always @(posedge clk) begin
    if (bus.vld && bus.rdy) begin
      $display("ldr write addr=%h we=%b wdat=%h", bus.addr, bus.we, bus.wdat);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_soc_ram_loader.sv
// Directed bench for soc_ram_loader against a small RAM stub slave.
module tb_soc_ram_loader;
  import soc_pkg::*;

  localparam soc_addr_t BASE = 32'h0000_0040;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       start = 1'b0;
  logic       s_vld = 1'b0;
  logic       s_rdy;
  logic [7:0] s_dat = 8'h00;
  logic       s_last = 1'b0;
  logic       busy, done, err;
  logic [1:0] wcnt;
  logic [15:0] csum;

  int total = 0;
  int bad = 0;

  soc_if bus_i ();

  soc_ram_loader #(.BASE_ADDR(BASE), .NUM_WORDS(2)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus_i), .start(start),
    .s_vld(s_vld), .s_rdy(s_rdy), .s_dat(s_dat), .s_last(s_last),
    .busy(busy), .done(done), .err(err), .wcnt(wcnt), .csum(csum)
  );

  always #5 clk = ~clk;

  // RAM stub: combinational rdy from |we, or rdy delayed by three cycles.
  logic      bp_on = 1'b0;
  logic [1:0] bp_cnt = 2'd0;
  logic      ram_clr = 1'b0;
  logic [31:0] mem [0:3];
  assign bus_i.rdy = bp_on ? (bus_i.vld && bp_cnt == 2'd3) : (|bus_i.we);

  always @(posedge clk) begin
    if (!bus_i.vld || bus_i.rdy) bp_cnt <= 2'd0;
    else bp_cnt <= bp_cnt + 2'd1;
  end

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4; i++) mem[i] <= 32'h0;
    end else if (bus_i.vld && bus_i.rdy) begin
      for (int b = 0; b < 4; b++)
        if (bus_i.we[b]) mem[bus_i.addr[3:2]][b*8 +: 8] <= bus_i.wdat[b*8 +: 8];
    end
  end

  // Bus monitor: write log, request stability and protocol side rules.
  logic [31:0] log_addr[$];
  logic [31:0] log_dat[$];
  logic [3:0]  log_we[$];
  int          log_len[$];
  logic        vld_prev = 1'b0;
  logic [31:0] p_addr, p_dat;
  logic [3:0]  p_we;
  int          cur_len = 0;
  int          unstable = 0;
  int          srdy_bad = 0;
  int          idle_bad = 0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (!bus_i.vld && (bus_i.we != 4'h0 || bus_i.wdat != 32'h0)) idle_bad <= idle_bad + 1;
    if (bus_i.vld) begin
      if (vld_prev && (bus_i.addr != p_addr || bus_i.wdat != p_dat || bus_i.we != p_we))
        unstable <= unstable + 1;
      if (s_rdy) srdy_bad <= srdy_bad + 1;
      if (bus_i.rdy) begin
        log_addr.push_back(bus_i.addr);
        log_dat.push_back(bus_i.wdat);
        log_we.push_back(bus_i.we);
        log_len.push_back(cur_len + 1);
        vld_prev <= 1'b0;
        cur_len  <= 0;
      end else begin
        vld_prev <= 1'b1;
        p_addr   <= bus_i.addr;
        p_dat    <= bus_i.wdat;
        p_we     <= bus_i.we;
        cur_len  <= cur_len + 1;
      end
    end else begin
      vld_prev <= 1'b0;
      cur_len  <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] w);
    chk({tag, "_addr"}, (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF, a);
    chk({tag, "_wdat"}, (i < log_dat.size()) ? log_dat[i] : 32'hDEAD_BEEF, d);
    chk({tag, "_we"}, (i < log_we.size()) ? {28'h0, log_we[i]} : 32'hF0, {28'h0, w});
  endtask

  // Called and returns at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_vld = 1'b1;
    s_dat = d;
    s_last = l;
    while (!s_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accept", {31'h0, (n < 100)}, 32'h1);
    @(negedge clk);
    s_vld = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'h0, done}, 32'h1);
  endtask

  initial begin
    int base;
    int dc;

    // Reset state
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_rdy", {31'h0, s_rdy}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_wcnt", {30'h0, wcnt}, 32'h0);
    chk("rst_csum", {16'h0, csum}, 32'h0);
    chk("rst_vld", {31'h0, bus_i.vld}, 32'h0);
    chk("rst_we", {28'h0, bus_i.we}, 32'h0);
    chk("rst_wdat", bus_i.wdat, 32'h0);
    chk("rst_addr", bus_i.addr, BASE);

    // Two full words
    base = log_addr.size();
    dc = done_cnt;
    pulse_start();
    chk("t1_busy", {31'h0, busy}, 32'h1);
    chk("t1_s_rdy", {31'h0, s_rdy}, 32'h1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    chk("t1_vld_lat", {31'h0, bus_i.vld}, 32'h1);
    chk("t1_vld_srdy", {31'h0, s_rdy}, 32'h0);
    chk("t1_vld_addr", bus_i.addr, BASE);
    for (int i = 5; i <= 8; i++) send_byte(8'(i), i == 8);
    wait_done();
    chk("t1_wcnt", {30'h0, wcnt}, 32'd2);
    chk("t1_csum", {16'h0, csum}, 32'h0024);
    chk("t1_err", {31'h0, err}, 32'h0);
    chk("t1_busy_done", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("t1_done_pulse", done_cnt - dc, 32'd1);
    chk("t1_nwr", log_addr.size() - base, 32'd2);
    chk_wr("t1_w0", base, BASE, 32'h0403_0201, 4'hF);
    chk_wr("t1_w1", base + 1, BASE + 4, 32'h0807_0605, 4'hF);

    // Partial last word
    base = log_addr.size();
    pulse_start();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b1);
    wait_done();
    chk("t2_wcnt", {30'h0, wcnt}, 32'd2);
    chk("t2_csum", {16'h0, csum}, 32'h03FC);
    chk_wr("t2_w0", base, BASE, 32'hDDCC_BBAA, 4'hF);
    chk_wr("t2_w1", base + 1, BASE + 4, 32'h0000_00EE, 4'h1);
    @(negedge clk);

    // Overflow with NUM_WORDS=2
    base = log_addr.size();
    dc = done_cnt;
    pulse_start();
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    chk("t3_drain_srdy", {31'h0, s_rdy}, 32'h1);
    chk("t3_drain_err", {31'h0, err}, 32'h1);
    for (int i = 10; i <= 12; i++) send_byte(8'(i), i == 12);
    wait_done();
    chk("t3_err", {31'h0, err}, 32'h1);
    chk("t3_wcnt", {30'h0, wcnt}, 32'd2);
    chk("t3_csum", {16'h0, csum}, 32'h0024);
    @(negedge clk);
    chk("t3_nwr", log_addr.size() - base, 32'd2);
    chk("t3_done_pulse", done_cnt - dc, 32'd1);
    chk("t3_err_sticky", {31'h0, err}, 32'h1);

    // Slave backpressure
    ram_clr = 1'b1;
    @(negedge clk);
    ram_clr = 1'b0;
    bp_on = 1'b1;
    base = log_addr.size();
    pulse_start();
    chk("t4_err_clr", {31'h0, err}, 32'h0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    wait_done();
    chk("t4_wcnt", {30'h0, wcnt}, 32'd2);
    chk("t4_len0", (base < log_len.size()) ? log_len[base] : -1, 32'd4);
    chk("t4_len1", (base + 1 < log_len.size()) ? log_len[base + 1] : -1, 32'd4);
    chk_wr("t4_w0", base, BASE, 32'h0403_0201, 4'hF);
    chk_wr("t4_w1", base + 1, BASE + 4, 32'h0807_0605, 4'hF);
    chk("t4_mem0", mem[0], 32'h0403_0201);
    chk("t4_mem1", mem[1], 32'h0807_0605);
    @(negedge clk);

    // Reset mid-load, during a stalled WRITE
    base = log_addr.size();
    pulse_start();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    chk("t5_in_write", {31'h0, bus_i.vld}, 32'h1);
    #1 arst_n = 1'b0;
    #1;
    chk("t5_vld", {31'h0, bus_i.vld}, 32'h0);
    chk("t5_we", {28'h0, bus_i.we}, 32'h0);
    chk("t5_wdat", bus_i.wdat, 32'h0);
    chk("t5_addr", bus_i.addr, BASE);
    chk("t5_busy", {31'h0, busy}, 32'h0);
    chk("t5_s_rdy", {31'h0, s_rdy}, 32'h0);
    chk("t5_wcnt", {30'h0, wcnt}, 32'h0);
    chk("t5_csum", {16'h0, csum}, 32'h0);
    @(negedge clk);
    bp_on = 1'b0;
    arst_n = 1'b1;
    @(negedge clk);
    chk("t5_nwr_rst", log_addr.size() - base, 32'd0);
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    wait_done();
    chk("t5_wcnt_new", {30'h0, wcnt}, 32'd1);
    chk("t5_csum_new", {16'h0, csum}, 32'h00AA);
    chk_wr("t5_w0", base, BASE, 32'h4433_2211, 4'hF);
    @(negedge clk);

    // Ignored start and bursty input
    base = log_addr.size();
    pulse_start();
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    pulse_start();
    send_byte(8'h02, 1'b0);
    repeat (3) @(negedge clk);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    @(negedge clk);
    chk("t6_wcnt_mid", {30'h0, wcnt}, 32'd1);
    pulse_start();
    chk("t6_wcnt_keep", {30'h0, wcnt}, 32'd1);
    chk("t6_csum_keep", {16'h0, csum}, 32'h000A);
    chk("t6_busy", {31'h0, busy}, 32'h1);
    repeat (2) @(negedge clk);
    send_byte(8'h05, 1'b1);
    wait_done();
    chk("t6_wcnt", {30'h0, wcnt}, 32'd2);
    chk("t6_csum", {16'h0, csum}, 32'h000F);
    chk("t6_err", {31'h0, err}, 32'h0);
    chk_wr("t6_w0", base, BASE, 32'h0403_0201, 4'hF);
    chk_wr("t6_w1", base + 1, BASE + 4, 32'h0000_0005, 4'h1);
    @(negedge clk);

    // Bus side rules over the whole run
    chk("g_unstable", unstable, 32'd0);
    chk("g_srdy_in_write", srdy_bad, 32'd0);
    chk("g_idle_we_wdat", idle_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/soc_ram_loader.md
# soc_ram_loader

- Bus master that sits directly upstream of the SoC RAM on the `soc_if` bus.
- Accepts a byte stream (for example, firmware from the UART boot path), packs the bytes little-endian into SoC words and writes them sequentially from `BASE_ADDR` with byte-lane write enables.
- Reports word count, checksum and overflow to the boot controller.

## Interface
Parameters:
- `BASE_ADDR`, default 0: byte address of the first word written; word-aligned, so bits below `SOC_ADDRL` are zero.
- `NUM_WORDS`, default 1024: capacity of the target region in SoC words.

Ports:
- `clk`  in  1: single clock; identical net to `bus.clk`.
- `arst_n`  in  1: reset, asynchronous and active-low; identical net to `bus.arst_n`.
- `bus`  `soc_if.MST`  –: drives `vld`, `we`, `addr`, `wdat`; samples `rdy`.
- `start`  in  1: one-cycle request to begin a load; ignored while `busy`.
- `s_vld`  in  1: byte valid.
- `s_rdy`  out  1: byte ready; a byte transfers on a rising edge with `s_vld & s_rdy`.
- `s_dat`  in  8: byte data.
- `s_last`  in  1: marks the final byte of the image; qualified by `s_vld`.
- `busy`  out  1: high from the cycle after `start` until `done`.
- `done`  out  1: one-cycle pulse at the end of a load.
- `err`  out  1: overflow flag; sticky until the next accepted `start`.
- `wcnt`  out  `$clog2(NUM_WORDS+1)`: number of words written in the current or last load.
- `csum`  out  16: sum of stored bytes, mod 2^16.

## Operation
States:
- IDLE:
  - `s_rdy`=0, `bus.vld`=0.
  - On `start`: go to FILL; clear `wcnt`, `csum`, `err` and the lane index; set word address to `BASE_ADDR`.
- FILL (`s_rdy`=1):
  - Each accepted byte goes to lane `lane_idx` (0..`SOC_BYTES`-1) of the word register; set that lane's bit in `we_acc`; add the byte to `csum`.
  - Go to WRITE when the byte fills lane `SOC_BYTES`-1 or carries `s_last`.
- WRITE (`s_rdy`=0):
  - `bus.vld`=1, `bus.we`=`we_acc`, `bus.addr`=current word address, `bus.wdat`=word register. Unfilled lanes are 0 with their `we` bit 0.
  - Hold all bus signals stable until `bus.rdy`.
  - On `vld & rdy`: increment `wcnt`, advance the address by one word, clear `we_acc`, `lane_idx` and the word register.
  - Next state is DONE if the last byte was packed, otherwise FILL.
- DRAIN (overflow):
  - Entered from FILL when a byte is accepted while `wcnt == NUM_WORDS`.
  - That byte and every later byte are accepted with `s_rdy`=1 and discarded; they are not added to `csum`.
  - `err`=1. Go to DONE on the byte carrying `s_last`, including the entry byte itself.
- DONE: `done`=1 for exactly one cycle, then IDLE.

Rules:
- `bus.we` and `bus.wdat` are `'0` whenever `bus.vld`=0. The slave derives `rdy` from `|we`, so a nonzero `we` outside WRITE would corrupt the handshake.
- The loader never issues reads.
- `start` is ignored in every state except IDLE.
- Address arithmetic uses the full `bus.addr` width; wrap above `NUM_WORDS` cannot occur because of the DRAIN state.

## Timing
- Reset values:
  - State IDLE.
  - `s_rdy`, `busy`, `done`, `err` = 0.
  - `wcnt`, `csum` = 0.
  - `bus.vld`, `bus.we`, `bus.wdat` = 0; `bus.addr` = `BASE_ADDR`.
- Reset asserted mid-load: everything returns to the reset values immediately, and no further bus cycle is issued. A RAM write already sampled stays in memory.
- `start` at edge T: `busy` and `s_rdy` are high from cycle T+1.
- Word completed by a byte accepted at edge N:
  - `bus.vld` is high in cycle N+1.
  - Against the SoC RAM, where write `rdy` is combinational, the write commits at edge N+1 and FILL resumes in cycle N+2.
  - Best-case throughput is `SOC_BYTES` bytes per `SOC_BYTES`+1 cycles.
- A slave that delays `rdy` k cycles stretches WRITE by k cycles; no byte is accepted meanwhile.
- `done` asserts the cycle after the final write handshake, or the cycle after the `s_last` byte in DRAIN. `busy` drops in the same cycle as `done`.
- `wcnt`, `csum` and `err` are final when `done` pulses and hold until the next `start`.

## Structure
- Use `soc_pkg` for `soc_data_t`, `soc_we_t`, `soc_addr_t`, `SOC_BYTES`, `SOC_ADDRL` and `HI`.
- Add `ldr_state_t` (IDLE, FILL, WRITE, DRAIN, DONE) to `soc_pkg` so that the boot controller and the bench can decode it.
- Single module, no sub-module. The byte packer is about 30 lines and stays inline.
- Sim-only `$display` of each write under `SIM_ONLY`/`LDR_DEBUG`.

## Test plan
- **Two full words.** Stimulus: `start`, then bytes 01..08 with `s_last` on 08. Required response:
  - Writes `0x04030201` to `BASE` and `0x08070605` to `BASE`+4, both with we=1111.
  - `wcnt`=2, `csum`=0x0024, `err`=0, one `done` pulse.
- **Partial last word.** Stimulus: 5 bytes AA BB CC DD EE. Required response:
  - Second write has we=0001 and wdat=`0x000000EE`.
  - `wcnt`=2, `csum`=0x03FC.
- **Overflow.** Stimulus: `NUM_WORDS`=2, 12 bytes. Required response:
  - Exactly 2 writes; bytes 9–12 are drained with `s_rdy`=1.
  - `err`=1, `wcnt`=2, `csum` equals the sum of bytes 1–8.
- **Slave backpressure.** Stimulus: stub slave holds `rdy` low for 3 cycles per write. Required response:
  - `vld`, `addr`, `wdat` and `we` stay stable for 4 cycles; `s_rdy`=0 throughout.
  - RAM contents are identical to the first test.
- **Reset mid-load.** Stimulus: drop `arst_n` during WRITE. Required response:
  - `bus.vld` and `we` fall immediately; all outputs reach their reset values.
  - A new `start` loads correctly from `BASE`.
- **Ignored start.** Stimulus: `start` pulsed while `busy`, plus bursty `s_vld` with gaps. Required response:
  - No restart and no counter clear.
  - Packing is unaffected by the idle gaps.
